uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_if.sv | 12 +
 rtl/uart_tx_scheduler.sv | 98 +++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side bus of the UART transmit scheduler: pending levels, per-requester bytes, grant.
interface uart_tx_scheduler_if;
    localparam int unsigned NREQ = 4;
    localparam int unsigned BW   = 8;

    logic [NREQ-1:0]    req;
    logic [NREQ*BW-1:0] req_byte;
    logic [NREQ-1:0]    grant;

    modport master (output req, output req_byte, input grant);
    modport slave  (input req, input req_byte, output grant);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding one byte at a time from four requesters into a UART transmitter,
// with a watchdog on the UART acknowledging the launch.
module uart_tx_scheduler #(
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    uart_tx_scheduler_if.slave   rq,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 uart_transmit,
    output logic [7:0]           uart_tx_byte,
    input  logic                 uart_is_transmitting
);
    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

    state_t         state;
    logic [1:0]     last_grant;
    logic [CW-1:0]  cnt;
    logic [1:0]     winner;
    logic [1:0]     idx;
    logic           found;
    logic           launch_c;

    // Search starts one past the last winner and wraps, so the last winner is checked last.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        idx    = last_grant;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = last_grant + 2'(k);
            if (!found && rq.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant is decided in the IDLE cycle itself; reset and a busy UART both veto it.
    assign launch_c = (state == IDLE) && !rst && enable && found && !uart_is_transmitting;
    assign rq.grant = launch_c ? (4'b0001 << winner) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 2'd3;
            cnt           <= '0;
            busy          <= 1'b0;
            err_timeout   <= 1'b0;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= 8'h00;
        end else begin
            uart_transmit <= 1'b0;
            err_timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch_c) begin
                        state         <= LAUNCH;
                        last_grant    <= winner;
                        uart_tx_byte  <= rq.req_byte[{winner, 3'b000} +: 8];
                        uart_transmit <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_BUSY;
                    cnt   <= CW'(START_TIMEOUT);
                end
                WAIT_BUSY: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                    if (uart_is_transmitting) begin
                        state <= WAIT_DONE;
                    end else if (cnt <= CW'(1)) begin
                        // UART never picked the byte up: give up and report it.
                        state       <= IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        cnt         <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_is_transmitting) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
